intersection: RTL and testbench

//   Pipelined ray/triangle intersection test for the FPGA ray tracer, using Cramer's rule in signed Q16.16.

---
 rtl/rt_pkg.sv | 30 +++
 rtl/vec3_cross.sv | 27 ++
 rtl/intersection.sv | 198 +++++++++++++++++++
 tb/tb_intersection.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rt_pkg.sv
// Shared types and widths for the ray tracer datapath.
// All external values are signed Q16.16. Internal widths grow so that
// differences, cross products and dot products are exact.
package rt_pkg;

   localparam int FRAC_BITS = 16;
   localparam int FIXED_W   = 32;
   localparam int DIFF_W    = FIXED_W + 1;
   localparam int CROSS_W   = 2 * DIFF_W + 1;
   localparam int DOT_W     = DIFF_W + CROSS_W + 2;
   localparam int CMP_W     = DOT_W + FIXED_W + 2;

   typedef logic signed [FIXED_W-1:0] fixed_t;
   typedef fixed_t [0:2]              vec3_t;
   typedef vec3_t  [0:1]              ray_t;
   typedef vec3_t  [0:2]              tri_t;

   typedef logic signed [DIFF_W-1:0]  diff_t;
   typedef diff_t [0:2]               dvec_t;
   typedef logic signed [CROSS_W-1:0] cross_t;
   typedef cross_t [0:2]              cvec_t;
   typedef logic signed [DOT_W-1:0]   dot_t;
   typedef logic signed [CMP_W-1:0]   cmp_t;

   // Exact difference of two Q16.16 values, widened by one bit.
   function automatic diff_t sub_ext(input fixed_t x, input fixed_t y);
      return DIFF_W'(x) - DIFF_W'(y);
   endfunction

endpackage

// File: rtl/vec3_cross.sv
// Combinational full-precision cross product a x b of two signed vectors.
// Output is 2*IN_W+1 bits wide so the difference of two products never wraps.
module vec3_cross #(
   parameter int IN_W = 33
) (
   input  logic [0:2][IN_W-1:0] i_a,
   input  logic [0:2][IN_W-1:0] i_b,
   output logic [0:2][2*IN_W:0] o_c
);

   localparam int OUT_W = 2 * IN_W + 1;

   logic signed [OUT_W-1:0] a_ext [0:2];
   logic signed [OUT_W-1:0] b_ext [0:2];

   // Sign-extend operands to the result width, then form the three components.
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         a_ext[k] = OUT_W'($signed(i_a[k]));
         b_ext[k] = OUT_W'($signed(i_b[k]));
      end
      o_c[0] = a_ext[1] * b_ext[2] - a_ext[2] * b_ext[1];
      o_c[1] = a_ext[2] * b_ext[0] - a_ext[0] * b_ext[2];
      o_c[2] = a_ext[0] * b_ext[1] - a_ext[1] * b_ext[0];
   end

endmodule

// File: rtl/intersection.sv
// Four-stage ray/triangle intersection test using Cramer's rule without a divider.
// Signs of the Cramer numerators are compared against the determinant, so the
// barycentric and t bounds are checked exactly on full-width integers.
module intersection
   import rt_pkg::*;
#(
   parameter fixed_t min_t = '0
) (
   input  logic                   i_clk,
   input  logic                   i_rstn,
   input  logic                   i_valid,
   input  logic [0:2][0:2][31:0]  i_triangle,
   input  logic [0:1][0:2][31:0]  i_ray,
   output logic                   o_valid,
   output logic [0:2][31:0]       o_normal,
   output logic                   o_invalid,
   output logic                   o_result
);

   logic  s1_valid_q, s1_valid_d;
   dvec_t s1_t1_q, s1_t1_d, s1_t2_q, s1_t2_d, s1_r_q, s1_r_d, s1_n_q, s1_n_d;

   cvec_t t2xn, rxn, t2xr, t1xt2;
   logic  unused_cross_bits;

   logic  s2_valid_q, s2_valid_d;
   dvec_t s2_t1_q, s2_t1_d, s2_r_q, s2_r_d;
   cvec_t s2_t2xn_q, s2_t2xn_d, s2_rxn_q, s2_rxn_d, s2_t2xr_q, s2_t2xr_d;
   vec3_t s2_normal_q, s2_normal_d;

   logic  s3_valid_q, s3_valid_d;
   dot_t  s3_det_q, s3_det_d, s3_da_q, s3_da_d, s3_db_q, s3_db_d, s3_dt_q, s3_dt_d;
   vec3_t s3_normal_q, s3_normal_d;

   logic  det_neg, det_zero, hit;
   dot_t  abs_det, da_s, db_s, dt_s;
   cmp_t  t_lhs, t_rhs;

   logic  out_valid_q, out_valid_d, out_result_q, out_result_d, out_invalid_q, out_invalid_d;
   vec3_t out_normal_q, out_normal_d;

   // S1: edge vectors t1=B-A, t2=C-A, r=E-A and the negated direction n=-D.
   always_comb begin
      s1_valid_d = i_valid;
      for (int k = 0; k < 3; k++) begin
         s1_t1_d[k] = sub_ext($signed(i_triangle[1][k]), $signed(i_triangle[0][k]));
         s1_t2_d[k] = sub_ext($signed(i_triangle[2][k]), $signed(i_triangle[0][k]));
         s1_r_d[k]  = sub_ext($signed(i_ray[0][k]), $signed(i_triangle[0][k]));
         s1_n_d[k]  = sub_ext(fixed_t'(0), $signed(i_ray[1][k]));
      end
   end

   // S1 register.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         s1_valid_q <= 1'b0;
         s1_t1_q    <= '0;
         s1_t2_q    <= '0;
         s1_r_q     <= '0;
         s1_n_q     <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_t1_q    <= s1_t1_d;
         s1_t2_q    <= s1_t2_d;
         s1_r_q     <= s1_r_d;
         s1_n_q     <= s1_n_d;
      end
   end

   vec3_cross #(.IN_W(DIFF_W)) u_t2xn  (.i_a(s1_t2_q), .i_b(s1_n_q),  .o_c(t2xn));
   vec3_cross #(.IN_W(DIFF_W)) u_rxn   (.i_a(s1_r_q),  .i_b(s1_n_q),  .o_c(rxn));
   vec3_cross #(.IN_W(DIFF_W)) u_t2xr  (.i_a(s1_t2_q), .i_b(s1_r_q),  .o_c(t2xr));
   vec3_cross #(.IN_W(DIFF_W)) u_t1xt2 (.i_a(s1_t1_q), .i_b(s1_t2_q), .o_c(t1xt2));

   // The face normal keeps only bits [47:16] of the Q32.32 product (wrapping);
   // the remaining bits are folded here so they read as deliberately dropped.
   assign unused_cross_bits = ^{t1xt2[0][CROSS_W-1:FRAC_BITS+FIXED_W], t1xt2[0][FRAC_BITS-1:0],
                                t1xt2[1][CROSS_W-1:FRAC_BITS+FIXED_W], t1xt2[1][FRAC_BITS-1:0],
                                t1xt2[2][CROSS_W-1:FRAC_BITS+FIXED_W], t1xt2[2][FRAC_BITS-1:0]};

   // S2: capture the cross products and convert the normal back to Q16.16.
   always_comb begin
      s2_valid_d = s1_valid_q;
      s2_t1_d    = s1_t1_q;
      s2_r_d     = s1_r_q;
      s2_t2xn_d  = t2xn;
      s2_rxn_d   = rxn;
      s2_t2xr_d  = t2xr;
      for (int k = 0; k < 3; k++) begin
         s2_normal_d[k] = t1xt2[k][FRAC_BITS +: FIXED_W];
      end
   end

   // S2 register.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         s2_valid_q  <= 1'b0;
         s2_t1_q     <= '0;
         s2_r_q      <= '0;
         s2_t2xn_q   <= '0;
         s2_rxn_q    <= '0;
         s2_t2xr_q   <= '0;
         s2_normal_q <= '0;
      end else begin
         s2_valid_q  <= s2_valid_d;
         s2_t1_q     <= s2_t1_d;
         s2_r_q      <= s2_r_d;
         s2_t2xn_q   <= s2_t2xn_d;
         s2_rxn_q    <= s2_rxn_d;
         s2_t2xr_q   <= s2_t2xr_d;
         s2_normal_q <= s2_normal_d;
      end
   end

   // S3: exact Q48.48 triple products det, Da, Db and Dt.
   always_comb begin
      s3_valid_d  = s2_valid_q;
      s3_normal_d = s2_normal_q;
      s3_det_d    = '0;
      s3_da_d     = '0;
      s3_db_d     = '0;
      s3_dt_d     = '0;
      for (int k = 0; k < 3; k++) begin
         s3_det_d = s3_det_d + DOT_W'($signed(s2_t1_q[k])) * DOT_W'($signed(s2_t2xn_q[k]));
         s3_da_d  = s3_da_d  + DOT_W'($signed(s2_r_q[k]))  * DOT_W'($signed(s2_t2xn_q[k]));
         s3_db_d  = s3_db_d  + DOT_W'($signed(s2_t1_q[k])) * DOT_W'($signed(s2_rxn_q[k]));
         s3_dt_d  = s3_dt_d  + DOT_W'($signed(s2_t1_q[k])) * DOT_W'($signed(s2_t2xr_q[k]));
      end
   end

   // S3 register.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         s3_valid_q  <= 1'b0;
         s3_det_q    <= '0;
         s3_da_q     <= '0;
         s3_db_q     <= '0;
         s3_dt_q     <= '0;
         s3_normal_q <= '0;
      end else begin
         s3_valid_q  <= s3_valid_d;
         s3_det_q    <= s3_det_d;
         s3_da_q     <= s3_da_d;
         s3_db_q     <= s3_db_d;
         s3_dt_q     <= s3_dt_d;
         s3_normal_q <= s3_normal_d;
      end
   end

   // S4 decision: fold the determinant sign into each numerator so every bound
   // becomes a plain signed compare; t is checked as Dt*s*2^16 >= min_t*|det|.
   always_comb begin
      det_neg  = s3_det_q[DOT_W-1];
      det_zero = (s3_det_q == '0);
      abs_det  = det_neg ? -s3_det_q : s3_det_q;
      da_s     = det_neg ? -s3_da_q  : s3_da_q;
      db_s     = det_neg ? -s3_db_q  : s3_db_q;
      dt_s     = det_neg ? -s3_dt_q  : s3_dt_q;
      t_lhs    = CMP_W'(dt_s) <<< FRAC_BITS;
      t_rhs    = CMP_W'(min_t) * CMP_W'(abs_det);
      hit      = !det_zero && !da_s[DOT_W-1] && !db_s[DOT_W-1] &&
                 ((da_s + db_s) <= abs_det) && (t_lhs >= t_rhs);
   end

   // Output stage: results load only with a valid request and otherwise hold.
   always_comb begin
      out_valid_d   = s3_valid_q;
      out_result_d  = out_result_q;
      out_invalid_d = out_invalid_q;
      out_normal_d  = out_normal_q;
      if (s3_valid_q) begin
         out_result_d  = hit;
         out_invalid_d = det_zero;
         out_normal_d  = s3_normal_q;
      end
   end

   // Output register.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         out_valid_q   <= 1'b0;
         out_result_q  <= 1'b0;
         out_invalid_q <= 1'b0;
         out_normal_q  <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_result_q  <= out_result_d;
         out_invalid_q <= out_invalid_d;
         out_normal_q  <= out_normal_d;
      end
   end

   assign o_valid   = out_valid_q;
   assign o_result  = out_result_q;
   assign o_invalid = out_invalid_q;
   assign o_normal  = out_normal_q;

endmodule

// File: tb/tb_intersection.sv
// Scoreboard bench for intersection: one instance with min_t=0 and one with
// min_t=1.0 see the same requests; expected results are queued at issue time
// and popped when o_valid appears.
module tb_intersection;

   logic                  i_clk = 1'b0;
   logic                  i_rstn;
   logic                  i_valid;
   logic [0:2][0:2][31:0] i_triangle;
   logic [0:1][0:2][31:0] i_ray;

   logic                  o_valid0, o_invalid0, o_result0;
   logic [0:2][31:0]      o_normal0;
   logic                  o_valid1, o_invalid1, o_result1;
   logic [0:2][31:0]      o_normal1;

   int num_checks     = 0;
   int num_errors     = 0;
   int cyc            = 0;
   int unexpected_cnt = 0;

   typedef struct {
      logic        hit0;
      logic        hit1;
      logic        inv;
      logic [95:0] nrm;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   localparam logic [287:0] TRI1 = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                                    32'h0002_0000, 32'h0003_0000, 32'h0002_0000,
                                    32'h0001_0000, 32'h0001_0000, 32'h0003_0000};
   localparam logic [287:0] TRI2 = {32'h0, 32'h0, 32'h0,
                                    32'h0001_0000, 32'h0, 32'h0,
                                    32'h0, 32'h0001_0000, 32'h0};
   localparam logic [95:0]  E0   = {32'h0, 32'h0001_0000, 32'h0001_0000};
   localparam logic [95:0]  E4   = {32'h0, 32'h0005_0000, 32'h0001_0000};
   localparam logic [95:0]  D1   = {32'h0003_0000, 32'h0000_8000, 32'h0001_8000};
   localparam logic [95:0]  D2   = {32'hFFFD_0000, 32'hFFFF_8000, 32'hFFFE_8000};
   localparam logic [95:0]  D3   = {32'h0001_0000, 32'h0002_0000, 32'h0001_0000};
   localparam logic [95:0]  DX   = {32'h0001_0000, 32'h0, 32'h0};
   localparam logic [95:0]  DZN  = {32'h0, 32'h0, 32'hFFFF_0000};
   localparam logic [95:0]  EQ1  = {32'h0000_4000, 32'h0000_4000, 32'h0001_0000};
   localparam logic [95:0]  EQ2  = {32'h0000_8000, 32'h0000_8000, 32'h0001_0000};
   localparam logic [95:0]  EQ3  = {32'h0000_C000, 32'h0000_C000, 32'h0001_0000};
   localparam logic [95:0]  NRM1 = {32'h0004_0000, 32'hFFFE_0000, 32'h0000_0000};
   localparam logic [95:0]  NRM2 = {32'h0, 32'h0, 32'h0001_0000};

   intersection u_dut0 (
      .i_clk      (i_clk),
      .i_rstn     (i_rstn),
      .i_valid    (i_valid),
      .i_triangle (i_triangle),
      .i_ray      (i_ray),
      .o_valid    (o_valid0),
      .o_normal   (o_normal0),
      .o_invalid  (o_invalid0),
      .o_result   (o_result0)
   );

   intersection #(.min_t(32'sh0001_0000)) u_dut1 (
      .i_clk      (i_clk),
      .i_rstn     (i_rstn),
      .i_valid    (i_valid),
      .i_triangle (i_triangle),
      .i_ray      (i_ray),
      .o_valid    (o_valid1),
      .o_normal   (o_normal1),
      .o_invalid  (o_invalid1),
      .o_result   (o_result1)
   );

   // Free-running clock and cycle counter used for latency checks.
   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [95:0] actual, input logic [95:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Drive one request and queue what both instances should answer.
   task automatic applyStimulus(input logic [287:0] tri_v, input logic [95:0] org_v,
                                input logic [95:0] dir_v, input logic hit0, input logic hit1,
                                input logic inv, input logic [95:0] nrm);
      exp_t e;
      i_triangle = tri_v;
      i_ray      = {org_v, dir_v};
      i_valid    = 1'b1;
      e.hit0     = hit0;
      e.hit1     = hit1;
      e.inv      = inv;
      e.nrm      = nrm;
      e.cyc      = cyc;
      sb_q.push_back(e);
      @(posedge i_clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      i_valid = 1'b0;
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic waitDrain(input int max_cycles);
      i_valid = 1'b0;
      for (int i = 0; i < max_cycles && sb_q.size() != 0; i++) begin
         @(posedge i_clk);
         #1;
      end
      checkOutput("drain", 96'(sb_q.size()), 96'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_flags"}, {90'd0, o_valid0, o_result0, o_invalid0, o_valid1, o_result1, o_invalid1}, 96'd0);
      checkOutput({tag, "_normal0"}, o_normal0, 96'd0);
      checkOutput({tag, "_normal1"}, o_normal1, 96'd0);
   endtask

   // Monitor: on every output beat pop the oldest expectation and compare.
   always @(negedge i_clk) begin
      if (o_valid0 || o_valid1) begin
         if (sb_q.size() == 0) begin
            unexpected_cnt++;
         end else begin
            mon_e = sb_q.pop_front();
            checkOutput("valid_pair", {94'd0, o_valid0, o_valid1}, 96'd3);
            checkOutput("latency", 96'(cyc - mon_e.cyc), 96'd4);
            checkOutput("invalid0", {95'd0, o_invalid0}, {95'd0, mon_e.inv});
            checkOutput("invalid1", {95'd0, o_invalid1}, {95'd0, mon_e.inv});
            checkOutput("result0", {95'd0, o_result0}, {95'd0, mon_e.hit0});
            checkOutput("result1_mint", {95'd0, o_result1}, {95'd0, mon_e.hit1});
            checkOutput("normal0", o_normal0, mon_e.nrm);
            checkOutput("normal1", o_normal1, mon_e.nrm);
         end
      end
   end

   // Bound on total simulation time.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence.
   initial begin
      i_rstn     = 1'b1;
      i_valid    = 1'b0;
      i_triangle = '0;
      i_ray      = '0;
      #3 i_rstn  = 1'b0;
      #1 checkAllZero("reset");
      repeat (2) @(posedge i_clk);
      #1 i_rstn = 1'b1;
      idleCycles(2);

      // Back-to-back requests: the four reference cases, a vertex hit with t==1,
      // then a second triangle with a positive determinant around edge b+a==1.
      applyStimulus(TRI1, E0,  D1,  1'b1, 1'b0, 1'b0, NRM1);
      applyStimulus(TRI1, E0,  D2,  1'b0, 1'b0, 1'b0, NRM1);
      applyStimulus(TRI1, E0,  D3,  1'b0, 1'b0, 1'b1, NRM1);
      applyStimulus(TRI1, E4,  DX,  1'b0, 1'b0, 1'b0, NRM1);
      applyStimulus(TRI1, E0,  DX,  1'b1, 1'b1, 1'b0, NRM1);
      applyStimulus(TRI2, EQ1, DZN, 1'b1, 1'b1, 1'b0, NRM2);
      applyStimulus(TRI2, EQ3, DZN, 1'b0, 1'b0, 1'b0, NRM2);
      applyStimulus(TRI2, EQ2, DZN, 1'b1, 1'b1, 1'b0, NRM2);
      waitDrain(20);

      // Outputs hold the last result once o_valid drops.
      idleCycles(2);
      checkOutput("hold_valid", {95'd0, o_valid0}, 96'd0);
      checkOutput("hold_result", {95'd0, o_result0}, 96'd1);
      checkOutput("hold_normal", o_normal0, NRM2);

      // Reset with two requests in flight: everything clears at once.
      applyStimulus(TRI1, E0, D1, 1'b1, 1'b0, 1'b0, NRM1);
      applyStimulus(TRI1, E0, D2, 1'b0, 1'b0, 1'b0, NRM1);
      #1;
      i_valid = 1'b0;
      i_rstn  = 1'b0;
      sb_q.delete();
      #1 checkAllZero("midrst");
      @(posedge i_clk);
      #1 i_rstn = 1'b1;
      idleCycles(8);
      checkOutput("stale_valid", 96'(unexpected_cnt), 96'd0);

      // First request after reset still arrives with latency 4.
      applyStimulus(TRI1, E0, D1, 1'b1, 1'b0, 1'b0, NRM1);
      applyStimulus(TRI1, E4, DX, 1'b0, 1'b0, 1'b0, NRM1);
      waitDrain(20);
      idleCycles(3);
      checkOutput("unexpected_valid", 96'(unexpected_cnt), 96'd0);

      $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
      $finish;
   end

endmodule
